sda_gmem_ar_4k_splitter: RTL and testbench
==========================================

Name: sda_gmem_ar_4k_splitter

Overview:
- Sits between the generated action core's global memory read port and the m_axi_gmem read channels of the SDAccel kernel wrapper.
- Splits INCR read bursts that cross a 4KB address boundary into legal sub-bursts, which AXI requires.
- Merges the returned R beats so that the action core sees exactly one RLAST per original request.
- Passes the AR sideband fields (lock, cache, prot, qos, region, user) through unchanged on every sub-burst.

Parameters:
ADDR_WIDTH, 64, AR address width
DATA_WIDTH, 64, R data width
ID_WIDTH, 1, ARID/RID width
SIDE_WIDTH, 17, bundled AR sideband width (lock, cache, prot, qos, region, user)
TRACK_DEPTH, 8, sub-burst tracking FIFO depth; power of 2, minimum 2

Ports:
ap_clk  in  1  kernel clock
ap_rst_n  in  1  asynchronous active-low reset
s_arvalid  in  1  upstream AR valid
s_arready  out  1  upstream AR ready
s_araddr  in  ADDR_WIDTH  start address
s_arlen  in  8  beats minus 1
s_arsize  in  3  log2 bytes per beat; never exceeds log2(DATA_WIDTH/8)
s_arburst  in  2  burst type
s_arid  in  ID_WIDTH  ID
s_arside  in  SIDE_WIDTH  sideband, passed through
m_arvalid  out  1  downstream AR valid
m_arready  in  1  downstream AR ready
m_araddr  out  ADDR_WIDTH  sub-burst address
m_arlen  out  8  sub-burst beats minus 1
m_arsize, m_arburst, m_arid, m_arside  out  3/2/ID_WIDTH/SIDE_WIDTH  copied from the captured request
m_rvalid  in  1  downstream R valid
m_rready  out  1  downstream R ready
m_rdata, m_rresp, m_rid  in  DATA_WIDTH/2/ID_WIDTH  R payload
m_rlast  in  1  sub-burst last
s_rvalid  out  1  = m_rvalid
s_rready  in  1  upstream R ready; drives m_rready
s_rdata, s_rresp, s_rid  out  same widths  passed through combinationally
s_rlast  out  1  merged last
split_count  out  32  statistics (see Optional Feature)

Behaviour:
- Reset (async assert, sync-deasserted by the wrapper): FSM=IDLE, FIFO empty, all registers 0; s_arready=1, m_arvalid=0, split_count=0.
- FSM states:
  - IDLE: s_arready=1. On s_arvalid capture addr, remaining beats (s_arlen+1, 9 bits) and all fields, then go to ISSUE. Latency from capture to m_arvalid is 1 cycle.
  - ISSUE: s_arready=0. m_arvalid=1 whenever the FIFO is not full at the start of the cycle.
    - On m_arvalid&m_arready: push last flag = (sub_beats == remaining).
    - Then remaining -= sub_beats and addr = aligned addr + (sub_beats << size).
    - When remaining reaches 0, go to IDLE.
    - A new request is accepted no earlier than the cycle after the final handshake.
- Sub-burst computation (INCR only):
  - bytes = 1<<size.
  - al = addr[11:0] & ~(bytes-1).
  - to_bound = (4096 - al) >> size.
  - sub_beats = min(remaining, to_bound); m_arlen = sub_beats-1.
  - The first sub-burst keeps the unaligned m_araddr = addr. Later sub-bursts start exactly on the 4K boundary.
- FIXED and WRAP bursts: issued once unchanged, with last flag = 1.
- m_ar* outputs are registered and stable while m_arvalid=1 && !m_arready.
- R path:
  - s_rlast = m_rlast & fifo_head_last. FIFO head is valid whenever R beats arrive.
  - Pop on m_rvalid&m_rready&m_rlast.
  - Push and pop in the same cycle is legal. When full, a same-cycle pop does not enable a push.
- Single outstanding original request per ID is not enforced. Ordering relies on the downstream returning R in AR order.
- Reset mid-burst: FSM and FIFO clear immediately; in-flight beats are dropped by the wrapper's kernel reset.

Optional Feature:
- Macro SDA_AR_SPLIT_STATS_EN.
- Defined: split_count increments by 1 for each extra sub-burst issued (handshake where last flag=0). It saturates at 0xFFFFFFFF and clears only on reset.
- Undefined: no counter logic; split_count tied to 0.

Test Plan:
- INCR addr 0x1000, len 15, size 3 -> one m_ar at 0x1000 len 15; s_rlast on beat 16 only; split_count 0.
- INCR addr 0x0FF0, len 7, size 3 -> m_ar (0x0FF0,len 1) then (0x1000,len 5); s_rlast only on beat 8; split_count 1.
- INCR addr 0x0FFC, len 3, size 3 (unaligned) -> (0x0FFC,len 0) then (0x1000,len 2); s_rlast on beat 4.
- INCR addr 0x0F00, len 255, size 3 -> (0x0F00,len 31) then (0x1000,len 223); 256 beats, single s_rlast.
- TRACK_DEPTH=2, m_rvalid held 0, three crossing requests -> m_arvalid deasserts after 2 pushes; resumes the cycle after the first RLAST pop.
- WRAP burst at 0x0FF0 len 3 -> passed unsplit with last=1; assert ap_rst_n=0 mid-ISSUE -> m_arvalid=0 and s_arready=1 immediately.

Source files
------------

// File: rtl/sda_gmem_ar_4k_splitter.sv
// sda_gmem_ar_4k_splitter
//   Sits between the action core's global-memory read port and m_axi_gmem.
//   INCR read bursts that cross a 4KB boundary are cut into legal sub-bursts.
//   The R beats coming back are merged so the core sees one RLAST per request.
//   AR sideband (lock/cache/prot/qos/region/user) rides unchanged on every
//   sub-burst.
//
// Ports
//   ap_clk, ap_rst_n        kernel clock, asynchronous active-low reset
//   s_ar*                   upstream AR channel (from the action core)
//   m_ar*                   downstream AR channel (to m_axi_gmem), registered
//   m_r*                    downstream R channel (from m_axi_gmem)
//   s_r*                    upstream R channel, combinational pass-through
//                           except s_rlast, which is the merged last
//   split_count             number of extra sub-bursts issued (saturating)
//
// Build option
//   SDA_AR_SPLIT_STATS_EN   defined: split_count is a live counter
//                           undefined: split_count is tied to 0
module sda_gmem_ar_4k_splitter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 1,
  parameter int SIDE_WIDTH  = 17,
  parameter int TRACK_DEPTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  // upstream AR
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [SIDE_WIDTH-1:0] s_arside,
  // downstream AR
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [SIDE_WIDTH-1:0] m_arside,
  // downstream R
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic                  m_rlast,
  // upstream R
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic                  s_rlast,
  // statistics
  output logic [31:0]           split_count
);

  localparam int          PTR_W = $clog2(TRACK_DEPTH);
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic {IDLE, ISSUE} state_t;

  // Beats that fit before the next 4KB boundary, capped by what is left.
  // FIXED/WRAP never cross by definition here and go out in one piece.
  function automatic logic [8:0] calc_sub(input logic [11:0] addr_lo,
                                          input logic [8:0]  rem,
                                          input logic [2:0]  size,
                                          input logic [1:0]  burst);
    logic [12:0] al;
    logic [12:0] to_bound;
    al       = {1'b0, addr_lo & (12'hFFF << size)};
    to_bound = (13'h1000 - al) >> size;
    if (burst != BURST_INCR || {4'b0, rem} <= to_bound) return rem;
    // to_bound < rem <= 256 here, so the truncation is lossless
    return to_bound[8:0];
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [8:0]              rem_q;
  logic [8:0]              sub_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [SIDE_WIDTH-1:0]   side_q;

  logic [TRACK_DEPTH-1:0]  fifo_mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          fifo_cnt;
  logic                    fifo_full;

  logic                    capture;
  logic                    ar_hs;
  logic                    push_last;
  logic                    pop;
  logic [8:0]              rem_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [8:0]              sub_next;
  logic [8:0]              sub_new;

  assign fifo_full = (fifo_cnt == (PTR_W+1)'(TRACK_DEPTH));
  assign s_arready = (state_q == IDLE);
  // Fullness is judged on the registered count only, so a pop in the same
  // cycle never opens the way for a push into a full FIFO.
  assign m_arvalid = (state_q == ISSUE) && !fifo_full;
  assign capture   = s_arready && s_arvalid;
  assign ar_hs     = m_arvalid && m_arready;
  assign push_last = (sub_q == rem_q);
  assign pop       = m_rvalid && s_rready && m_rlast && (fifo_cnt != '0);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rem_next  = rem_q - sub_q;
    // Later sub-bursts start on the boundary: align, then step past the beats.
    addr_next = (addr_q & ({ADDR_WIDTH{1'b1}} << size_q))
              + (ADDR_WIDTH'(sub_q) << size_q);
    sub_next  = calc_sub(addr_next[11:0], rem_next, size_q, burst_q);
    sub_new   = capture ? calc_sub(s_araddr[11:0], {1'b0, s_arlen} + 9'd1,
                                   s_arsize, s_arburst)
                        : sub_next;
    case (state_q)
      IDLE:    if (s_arvalid) state_d = ISSUE;
      ISSUE:   if (ar_hs && rem_next == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sub_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= s_araddr;
        rem_q   <= {1'b0, s_arlen} + 9'd1;
        size_q  <= s_arsize;
        burst_q <= s_arburst;
        id_q    <= s_arid;
        side_q  <= s_arside;
        sub_q   <= sub_new;
        len_q   <= 8'(sub_new - 9'd1);
      end else if (ar_hs) begin
        addr_q  <= addr_next;
        rem_q   <= rem_next;
        sub_q   <= sub_new;
        len_q   <= 8'(sub_new - 9'd1);
      end
    end
  end

  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;
  assign m_arid    = id_q;
  assign m_arside  = side_q;

  // Tracking FIFO: one "this sub-burst ends the original request" bit per
  // issued sub-burst, consumed in AR order as sub-burst RLASTs come back.
  // NOTE: the storage is tiny and a defined head after reset keeps s_rlast
  // free of X, so it is reset along with the pointers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (ar_hs) begin
        fifo_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({ar_hs, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_rready = s_rready;
  assign s_rvalid = m_rvalid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rid    = m_rid;
  assign s_rlast  = m_rlast && fifo_mem[rd_ptr];

`ifdef SDA_AR_SPLIT_STATS_EN
  logic [31:0] split_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      split_q <= '0;
    end else if (ar_hs && !push_last && split_q != 32'hFFFF_FFFF) begin
      split_q <= split_q + 32'd1;
    end
  end

  assign split_count = split_q;
`else
  assign split_count = 32'd0;
`endif

endmodule

// File: tb/tb_sda_gmem_ar_4k_splitter.sv
// Directed bench for sda_gmem_ar_4k_splitter (TRACK_DEPTH=2 so the
// FIFO-full case is reachable with short stimulus).
module tb_sda_gmem_ar_4k_splitter;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        s_arvalid, s_arready;
  logic [63:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [0:0]  s_arid;
  logic [16:0] s_arside;
  logic        m_arvalid, m_arready;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [0:0]  m_arid;
  logic [16:0] m_arside;
  logic        m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [0:0]  m_rid;
  logic        m_rlast;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [0:0]  s_rid;
  logic        s_rlast;
  logic [31:0] split_count;

  always #5 ap_clk = ~ap_clk;

  sda_gmem_ar_4k_splitter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(1), .SIDE_WIDTH(17),
    .TRACK_DEPTH(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arid(s_arid), .s_arside(s_arside),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arside(m_arside),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
    .split_count(split_count)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [16:0] side;
    logic [0:0]  id;
  } ar_rec_t;

  ar_rec_t ar_q[$];
  int      r_idx = 0;
  int      n_checks = 0;
  int      n_fail = 0;

  // AR handshakes are recorded mid-cycle; the handshake lands on the next edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && m_arvalid && m_arready)
      ar_q.push_back('{m_araddr, m_arlen, m_arburst, m_arside, m_arid});
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_split(input int n);
`ifdef SDA_AR_SPLIT_STATS_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic check_ar(input string tag, input int idx,
                          input logic [63:0] a, input logic [7:0] l);
    if (ar_q.size() > idx) begin
      check({tag, "_addr"}, ar_q[idx].addr, a);
      check({tag, "_len"},  ar_q[idx].len,  64'(l));
    end else begin
      check({tag, "_missing"}, 64'(ar_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic send_ar(input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] b,
                         input logic [0:0] id, input logic [16:0] side);
    int n = 0;
    @(negedge ap_clk);
    s_arvalid = 1'b1; s_araddr = a; s_arlen = l; s_arsize = sz;
    s_arburst = b; s_arid = id; s_arside = side;
    while (!s_arready && n < 1000) begin
      @(negedge ap_clk);
      n++;
    end
    if (!s_arready) check("ar_accept_timeout", 64'(s_arready), 64'd1);
    @(posedge ap_clk);
    #1 s_arvalid = 1'b0;
  endtask

  // Returns R for the next n_subs recorded sub-bursts, in AR order.
  task automatic return_r(input int n_subs, output int rlast_cnt,
                          output int rlast_pos);
    int beat = 0;
    int bad  = 0;
    rlast_cnt = 0;
    rlast_pos = 0;
    for (int s = 0; s < n_subs; s++) begin
      int n = 0;
      int len;
      while (ar_q.size() <= r_idx && n < 1000) begin
        @(posedge ap_clk);
        #1 n++;
      end
      if (ar_q.size() <= r_idx) begin
        check("r_wait_timeout", 64'(ar_q.size()), 64'(r_idx + 1));
        return;
      end
      len = int'(ar_q[r_idx].len);
      r_idx++;
      for (int b = 0; b <= len; b++) begin
        @(negedge ap_clk);
        m_rvalid = 1'b1;
        m_rlast  = (b == len);
        m_rdata  = 64'hD000_0000 + 64'(beat);
        #1;
        if (s_rlast) begin
          rlast_cnt++;
          rlast_pos = beat + 1;
        end
        if (s_rdata !== m_rdata || s_rvalid !== 1'b1) bad++;
        beat++;
        @(posedge ap_clk);
        #1 m_rvalid = 1'b0;
        m_rlast = 1'b0;
      end
    end
    check("r_passthrough", 64'(bad), 64'd0);
  endtask

  initial begin
    int base, cnt, pos;
    ap_rst_n = 1'b0;
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_arid = 0; s_arside = 0; m_arready = 1'b1;
    m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rid = 0; m_rlast = 0;
    s_rready = 1'b1;
    repeat (3) @(negedge ap_clk);
    check("rst_s_arready", 64'(s_arready), 64'd1);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_split",     64'(split_count), 64'd0);
    check("rst_m_rready",  64'(m_rready), 64'd1);
    ap_rst_n = 1'b1;

    // Aligned, no crossing
    base = ar_q.size();
    send_ar(64'h1000, 8'd15, 3'd3, 2'b01, 1'b0, 17'h00000);
    @(negedge ap_clk);
    check("t1_latency_arvalid", 64'(m_arvalid), 64'd1);
    return_r(1, cnt, pos);
    check("t1_ar_count", 64'(ar_q.size() - base), 64'd1);
    check_ar("t1_ar0", base, 64'h1000, 8'd15);
    check("t1_rlast_cnt", 64'(cnt), 64'd1);
    check("t1_rlast_pos", 64'(pos), 64'd16);
    check("t1_split", 64'(split_count), 64'(exp_split(0)));

    // Crossing at 0x0FF0: 2 beats before boundary, 6 after
    base = ar_q.size();
    send_ar(64'h0FF0, 8'd7, 3'd3, 2'b01, 1'b0, 17'h00000);
    return_r(2, cnt, pos);
    check("t2_ar_count", 64'(ar_q.size() - base), 64'd2);
    check_ar("t2_ar0", base,     64'h0FF0, 8'd1);
    check_ar("t2_ar1", base + 1, 64'h1000, 8'd5);
    check("t2_rlast_cnt", 64'(cnt), 64'd1);
    check("t2_rlast_pos", 64'(pos), 64'd8);
    check("t2_split", 64'(split_count), 64'(exp_split(1)));

    // Unaligned start 0x0FFC: one beat fits, next starts on the boundary
    base = ar_q.size();
    send_ar(64'h0FFC, 8'd3, 3'd3, 2'b01, 1'b0, 17'h00000);
    return_r(2, cnt, pos);
    check_ar("t3_ar0", base,     64'h0FFC, 8'd0);
    check_ar("t3_ar1", base + 1, 64'h1000, 8'd2);
    check("t3_rlast_cnt", 64'(cnt), 64'd1);
    check("t3_rlast_pos", 64'(pos), 64'd4);

    // Max length crossing, with sideband/ID pass-through
    base = ar_q.size();
    send_ar(64'h0F00, 8'd255, 3'd3, 2'b01, 1'b1, 17'h1ABCD);
    return_r(2, cnt, pos);
    check_ar("t4_ar0", base,     64'h0F00, 8'd31);
    check_ar("t4_ar1", base + 1, 64'h1000, 8'd223);
    if (ar_q.size() > base + 1) begin
      check("t4_side0", 64'(ar_q[base].side),     64'h1ABCD);
      check("t4_side1", 64'(ar_q[base + 1].side), 64'h1ABCD);
      check("t4_id1",   64'(ar_q[base + 1].id),   64'd1);
    end
    check("t4_rlast_cnt", 64'(cnt), 64'd1);
    check("t4_rlast_pos", 64'(pos), 64'd256);
    check("t4_split", 64'(split_count), 64'(exp_split(3)));

    // FIFO full: R withheld, two crossing requests fill the 2-entry FIFO
    base = ar_q.size();
    send_ar(64'h0FF0, 8'd7, 3'd3, 2'b01, 1'b0, 17'h00000);
    send_ar(64'h1FF0, 8'd7, 3'd3, 2'b01, 1'b0, 17'h00000);
    repeat (3) @(negedge ap_clk);
    check("full_arvalid_low", 64'(m_arvalid), 64'd0);
    check("full_ar_count",    64'(ar_q.size() - base), 64'd2);
    check("full_s_arready",   64'(s_arready), 64'd0);
    return_r(1, cnt, pos);
    check("full_a1_no_rlast", 64'(cnt), 64'd0);
    @(negedge ap_clk);
    check("full_resume_arvalid", 64'(m_arvalid), 64'd1);
    return_r(3, cnt, pos);
    check_ar("full_b1", base + 2, 64'h1FF0, 8'd1);
    check_ar("full_b2", base + 3, 64'h2000, 8'd5);
    check("full_rlast_cnt", 64'(cnt), 64'd2);
    check("full_rlast_pos", 64'(pos), 64'd14);
    send_ar(64'h2FF8, 8'd1, 3'd3, 2'b01, 1'b0, 17'h00000);
    return_r(2, cnt, pos);
    check_ar("full_c1", base + 5, 64'h3000, 8'd0);
    check("full_c_rlast_pos", 64'(pos), 64'd2);
    check("full_split", 64'(split_count), 64'(exp_split(6)));

    // WRAP crossing 0x0FF0 is not split and ends the request
    base = ar_q.size();
    send_ar(64'h0FF0, 8'd3, 3'd3, 2'b10, 1'b0, 17'h00000);
    return_r(1, cnt, pos);
    check("wrap_ar_count", 64'(ar_q.size() - base), 64'd1);
    check_ar("wrap_ar0", base, 64'h0FF0, 8'd3);
    if (ar_q.size() > base) check("wrap_burst", 64'(ar_q[base].burst), 64'd2);
    check("wrap_rlast_pos", 64'(pos), 64'd4);
    check("wrap_split", 64'(split_count), 64'(exp_split(6)));

    // Reset while ISSUE is stalled by m_arready=0
    m_arready = 1'b0;
    send_ar(64'h0FF0, 8'd7, 3'd3, 2'b01, 1'b0, 17'h00000);
    repeat (2) @(negedge ap_clk);
    check("stall_arvalid", 64'(m_arvalid), 64'd1);
    check("stall_araddr",  m_araddr, 64'h0FF0);
    check("stall_arlen",   64'(m_arlen), 64'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("midrst_arvalid",  64'(m_arvalid), 64'd0);
    check("midrst_arready",  64'(s_arready), 64'd1);
    check("midrst_split",    64'(split_count), 64'd0);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    m_arready = 1'b1;
    repeat (2) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
